// File: rtl/vga_pkg.sv
// Shared definitions for the VGA rectangle fill sequencer: register map,
// screen-size helpers, FSM state encoding and the command record.
package vga_pkg;

  // Byte offsets of the VGA peripheral's worker registers from its base.
  typedef enum logic [4:0] {
    REG_EN           = 5'h00,
    REG_X_ADDR       = 5'h04,
    REG_Y_ADDR       = 5'h08,
    REG_DATA         = 5'h0C,
    REG_PALETTE_ADDR = 5'h10,
    REG_COLOR        = 5'h14,
    REG_SCANLINE     = 5'h1C
  } vga_reg_e;

  function automatic logic [11:0] max_w(input int div);
    return 12'(1280 >> div);
  endfunction

  function automatic logic [10:0] max_h(input int div);
    return 11'(960 >> div);
  endfunction

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VBL,
    ST_VBL_GAP,
    ST_WR_X,
    ST_WR_Y,
    ST_WR_DATA,
    ST_DONE
  } fill_state_e;

  // Colour is carried at the widest (direct 24-bit) size and zero-extended.
  typedef struct packed {
    logic [10:0] x;
    logic [9:0]  y;
    logic [10:0] w;
    logic [9:0]  h;
    logic [23:0] color;
    logic        vblank;
  } fill_cmd_t;

endpackage

// File: rtl/vga_fill_clip.sv
// Combinational clip of a fill rectangle to the visible screen, plus
// detection of commands that cover no visible pixel.
module vga_fill_clip
  import vga_pkg::*;
#(
  parameter int W_DIV_1280 = 1,
  parameter int H_DIV_960  = 1
) (
  input  logic [10:0] x,
  input  logic [9:0]  y,
  input  logic [10:0] w,
  input  logic [9:0]  h,
  output logic [10:0] x_end,
  output logic [9:0]  y_end,
  output logic        empty
);

  localparam logic [11:0] MAX_W = max_w(W_DIV_1280);
  localparam logic [10:0] MAX_H = max_h(H_DIV_960);

  logic [11:0] x_sum;
  logic [10:0] y_sum;

  // Sums are one bit wider than the operands so x+w cannot wrap below MAX.
  always_comb begin
    x_sum = {1'b0, x} + {1'b0, w};
    y_sum = {1'b0, y} + {1'b0, h};
    x_end = (x_sum > MAX_W) ? MAX_W[10:0] : x_sum[10:0];
    y_end = (y_sum > MAX_H) ? MAX_H[9:0] : y_sum[9:0];
    empty = (w == 11'd0) || (h == 10'd0) ||
            ({1'b0, x} >= MAX_W) || ({1'b0, y} >= MAX_H);
  end

endmodule

// File: rtl/vga_rect_fill_sequencer.sv
// Bus master that fills a clipped rectangle with one colour by writing the
// VGA peripheral's X/Y/DATA registers, optionally waiting for vblank first.
module vga_rect_fill_sequencer
  import vga_pkg::*;
#(
  parameter logic [31:0] VGA_ADDR   = 32'h1000_0000,
  parameter int          DEPTH      = 3,
  parameter int          W_DIV_1280 = 1,
  parameter int          H_DIV_960  = 1,
  localparam int         CW         = (DEPTH == 0) ? 24 : DEPTH
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [10:0]   cmd_x,
  input  logic [9:0]    cmd_y,
  input  logic [10:0]   cmd_w,
  input  logic [9:0]    cmd_h,
  input  logic [CW-1:0] cmd_color,
  input  logic          cmd_vblank,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic          aborted,
  output logic [31:0]   wr_addr,
  output logic [31:0]   wr_data,
  output logic [3:0]    wr_byteEn,
  output logic          wr_valid,
  input  logic          wr_ready,
  output logic [31:0]   rd_addr,
  output logic [3:0]    rd_byteEn,
  output logic          rd_valid,
  input  logic          rd_ready,
  input  logic [31:0]   rd_data
);

  // Handshake: a beat transfers on a clock edge with valid && ready. While a
  // beat is pending, valid, addr and data hold; on the transfer edge the next
  // beat is presented or valid drops. cmd_valid/cmd_ready follow the same rule.

  fill_state_e state_q, state_d;
  logic        started_q, started_d;
  logic        empty_done_q, empty_done_d;
  logic        aborted_q, aborted_d;
  logic [10:0] x_start_q, x_start_d;
  logic [10:0] cur_x_q, cur_x_d;
  logic [9:0]  cur_y_q, cur_y_d;
  logic [10:0] x_end_q, x_end_d;
  logic [9:0]  y_end_q, y_end_d;
  logic [23:0] color_q, color_d;

  fill_cmd_t   cmd_s;
  logic [10:0] clip_x_end;
  logic [9:0]  clip_y_end;
  logic        clip_empty;
  logic        last_x, last_y;
  logic        unused_rd;

  assign unused_rd = ^rd_data[31:10];

  always_comb begin
    cmd_s.x      = cmd_x;
    cmd_s.y      = cmd_y;
    cmd_s.w      = cmd_w;
    cmd_s.h      = cmd_h;
    cmd_s.color  = 24'(cmd_color);
    cmd_s.vblank = cmd_vblank;
  end

  vga_fill_clip #(
    .W_DIV_1280 (W_DIV_1280),
    .H_DIV_960  (H_DIV_960)
  ) u_clip (
    .x     (cmd_s.x),
    .y     (cmd_s.y),
    .w     (cmd_s.w),
    .h     (cmd_s.h),
    .x_end (clip_x_end),
    .y_end (clip_y_end),
    .empty (clip_empty)
  );

  assign last_x = ({1'b0, cur_x_q} + 12'd1) == {1'b0, x_end_q};
  assign last_y = ({1'b0, cur_y_q} + 11'd1) == {1'b0, y_end_q};

  always_comb begin
    state_d      = state_q;
    started_d    = 1'b1;
    empty_done_d = 1'b0;
    aborted_d    = 1'b0;
    x_start_d    = x_start_q;
    cur_x_d      = cur_x_q;
    cur_y_d      = cur_y_q;
    x_end_d      = x_end_q;
    y_end_d      = y_end_q;
    color_d      = color_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          // Empty commands never leave IDLE, so busy stays low for them.
          if (clip_empty) begin
            empty_done_d = 1'b1;
          end else begin
            x_start_d = cmd_s.x;
            cur_x_d   = cmd_s.x;
            cur_y_d   = cmd_s.y;
            x_end_d   = clip_x_end;
            y_end_d   = clip_y_end;
            color_d   = cmd_s.color;
            state_d   = cmd_s.vblank ? ST_VBL : ST_WR_X;
          end
        end
      end
      ST_VBL: begin
        if (rd_ready) begin
          if (abort) begin
            state_d   = ST_DONE;
            aborted_d = 1'b1;
          end else if (rd_data[9:0] == 10'd0) begin
            state_d = ST_WR_X;
          end else begin
            state_d = ST_VBL_GAP;
          end
        end
      end
      ST_VBL_GAP: begin
        if (abort) begin
          state_d   = ST_DONE;
          aborted_d = 1'b1;
        end else begin
          state_d = ST_VBL;
        end
      end
      ST_WR_X: begin
        if (wr_ready) begin
          if (abort) begin
            state_d   = ST_DONE;
            aborted_d = 1'b1;
          end else begin
            state_d = ST_WR_Y;
          end
        end
      end
      ST_WR_Y: begin
        if (wr_ready) begin
          if (abort) begin
            state_d   = ST_DONE;
            aborted_d = 1'b1;
          end else begin
            state_d = ST_WR_DATA;
          end
        end
      end
      ST_WR_DATA: begin
        // The peripheral advances X itself; only row starts need X/Y writes.
        if (wr_ready) begin
          if (abort) begin
            state_d   = ST_DONE;
            aborted_d = 1'b1;
          end else if (last_x) begin
            cur_x_d = x_start_q;
            if (last_y) begin
              state_d = ST_DONE;
            end else begin
              cur_y_d = cur_y_q + 10'd1;
              state_d = ST_WR_X;
            end
          end else begin
            cur_x_d = cur_x_q + 11'd1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      started_q    <= 1'b0;
      empty_done_q <= 1'b0;
      aborted_q    <= 1'b0;
      x_start_q    <= '0;
      cur_x_q      <= '0;
      cur_y_q      <= '0;
      x_end_q      <= '0;
      y_end_q      <= '0;
      color_q      <= '0;
    end else begin
      state_q      <= state_d;
      started_q    <= started_d;
      empty_done_q <= empty_done_d;
      aborted_q    <= aborted_d;
      x_start_q    <= x_start_d;
      cur_x_q      <= cur_x_d;
      cur_y_q      <= cur_y_d;
      x_end_q      <= x_end_d;
      y_end_q      <= y_end_d;
      color_q      <= color_d;
    end
  end

  // All outputs decode registered state, so reset clears them immediately.
  always_comb begin
    cmd_ready = started_q && (state_q == ST_IDLE);
    busy      = (state_q != ST_IDLE);
    done      = (state_q == ST_DONE) || empty_done_q;
    aborted   = aborted_q;
    wr_valid  = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    rd_valid  = 1'b0;
    rd_addr   = '0;
    case (state_q)
      ST_WR_X: begin
        wr_valid = 1'b1;
        wr_addr  = VGA_ADDR + 32'(REG_X_ADDR);
        wr_data  = 32'(x_start_q);
      end
      ST_WR_Y: begin
        wr_valid = 1'b1;
        wr_addr  = VGA_ADDR + 32'(REG_Y_ADDR);
        wr_data  = 32'(cur_y_q);
      end
      ST_WR_DATA: begin
        wr_valid = 1'b1;
        wr_addr  = VGA_ADDR + 32'(REG_DATA);
        wr_data  = 32'(color_q);
      end
      ST_VBL: begin
        rd_valid = 1'b1;
        rd_addr  = VGA_ADDR + 32'(REG_SCANLINE);
      end
      default: ;
    endcase
    wr_byteEn = wr_valid ? 4'hF : 4'h0;
    rd_byteEn = rd_valid ? 4'hF : 4'h0;
  end

endmodule

// File: tb/tb_vga_rect_fill_sequencer.sv
// Directed bench for vga_rect_fill_sequencer at default parameters
// (640x480, 3-bit colour, base 'h1000_0000).
module tb_vga_rect_fill_sequencer;

  localparam logic [31:0] A_X = 32'h1000_0004;
  localparam logic [31:0] A_Y = 32'h1000_0008;
  localparam logic [31:0] A_D = 32'h1000_000C;
  localparam logic [31:0] A_S = 32'h1000_001C;

  // clock / reset
  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic reset_n;

  logic        cmd_valid, cmd_ready, cmd_vblank, abort;
  logic [10:0] cmd_x, cmd_w;
  logic [9:0]  cmd_y, cmd_h;
  logic [2:0]  cmd_color;
  logic        busy, done, aborted;
  logic [31:0] wr_addr, wr_data, rd_addr, rd_data;
  logic [3:0]  wr_byteEn, rd_byteEn;
  logic        wr_valid, wr_ready, rd_valid, rd_ready;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  vga_rect_fill_sequencer dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_x      (cmd_x),
    .cmd_y      (cmd_y),
    .cmd_w      (cmd_w),
    .cmd_h      (cmd_h),
    .cmd_color  (cmd_color),
    .cmd_vblank (cmd_vblank),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .aborted    (aborted),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_byteEn  (wr_byteEn),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .rd_addr    (rd_addr),
    .rd_byteEn  (rd_byteEn),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .rd_data    (rd_data)
  );

  // scoreboard: observed beats and pulses, sampled on the falling edge
  logic [63:0] exp_q[$];
  logic [63:0] obs_q[$];
  int          obs_cyc[$];
  int          rd_cyc[$];
  logic [31:0] rd_addr_seen = '0;
  int          done_cnt = 0;
  int          done_cyc = -1;
  int          aborted_cnt = 0;
  int          busy_cnt = 0;

  always @(negedge clock) begin
    if (wr_valid && wr_ready) begin
      obs_q.push_back({wr_addr, wr_data});
      obs_cyc.push_back(cyc);
    end
    if (rd_valid && rd_ready) begin
      rd_cyc.push_back(cyc);
      rd_addr_seen = rd_addr;
    end
    if (done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
    if (aborted) aborted_cnt = aborted_cnt + 1;
    if (busy) busy_cnt = busy_cnt + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic send_cmd(input logic [10:0] x, input logic [9:0] y,
                          input logic [10:0] w, input logic [9:0] h,
                          input logic [2:0] c, input logic vb, output int acc);
    logic r;
    logic got;
    got = 1'b0;
    acc = -1;
    @(posedge clock); #1;
    cmd_valid = 1'b1; cmd_x = x; cmd_y = y; cmd_w = w; cmd_h = h;
    cmd_color = c; cmd_vblank = vb;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clock);
      r = cmd_ready;
      if (r) acc = cyc;
      @(posedge clock); #1;
      if (r) got = 1'b1;
    end
    cmd_valid = 1'b0;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL cmd_accept: cmd_ready=%0b after 50 cycles, required 1", cmd_ready);
    end
  endtask

  task automatic wait_done(input int base_d, input int budget);
    int n;
    n = 0;
    while (done_cnt == base_d && n < budget) begin
      @(posedge clock); #1;
      n++;
    end
    checks++;
    if (done_cnt == base_d) begin
      errors++;
      $display("FAIL done_timeout: no done after %0d cycles, required a pulse", budget);
    end
    repeat (3) @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;
  endtask

  // tests
  task automatic test_reset();
    #2;
    checks++;
    if ({cmd_ready, busy, done, aborted, wr_valid, rd_valid} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b, required 000000",
               {cmd_ready, busy, done, aborted, wr_valid, rd_valid});
    end
    checks++;
    if ({wr_addr, wr_data, rd_addr, wr_byteEn, rd_byteEn} !== 104'd0) begin
      errors++;
      $display("FAIL reset_bus: wr_addr=%h wr_data=%h rd_addr=%h be=%h/%h, required 0",
               wr_addr, wr_data, rd_addr, wr_byteEn, rd_byteEn);
    end
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_before_edge: cmd_ready=%b, required 0", cmd_ready);
    end
    @(posedge clock); #1;
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ready_after_edge: cmd_ready=%b busy=%b, required 1 0", cmd_ready, busy);
    end
  endtask

  task automatic test_fill();
    int bo, bd, acc, last;
    bo = obs_q.size(); bd = done_cnt;
    exp_q.delete();
    for (int r = 0; r < 2; r++) begin
      exp_q.push_back({A_X, 32'd10});
      exp_q.push_back({A_Y, 32'd20 + 32'(r)});
      for (int p = 0; p < 3; p++) exp_q.push_back({A_D, 32'd5});
    end
    send_cmd(11'd10, 10'd20, 11'd3, 10'd2, 3'd5, 1'b0, acc);
    wait_done(bd, 200);
    checks++;
    if (obs_q.size() - bo != exp_q.size()) begin
      errors++;
      $display("FAIL fill_count: got %0d beats, required %0d", obs_q.size() - bo, exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (bo + i >= obs_q.size() || obs_q[bo + i] !== exp_q[i]) begin
        errors++;
        $display("FAIL fill_beat%0d: got %h, required %h", i,
                 (bo + i < obs_q.size()) ? obs_q[bo + i] : 64'hx, exp_q[i]);
      end
    end
    if (obs_q.size() - bo == 10) begin
      last = obs_cyc[bo + 9];
      checks++;
      if (obs_cyc[bo] != acc + 1 || last - obs_cyc[bo] != 9) begin
        errors++;
        $display("FAIL fill_timing: first beat cyc %0d last %0d, required %0d and %0d",
                 obs_cyc[bo], last, acc + 1, acc + 10);
      end
      checks++;
      if (done_cyc != last + 1 || done_cnt - bd != 1) begin
        errors++;
        $display("FAIL fill_done: done cyc %0d count %0d, required %0d and 1",
                 done_cyc, done_cnt - bd, last + 1);
      end
    end
  endtask

  task automatic test_clip();
    int bo, bd, acc;
    bo = obs_q.size(); bd = done_cnt;
    exp_q.delete();
    exp_q.push_back({A_X, 32'd638});
    exp_q.push_back({A_Y, 32'd479});
    exp_q.push_back({A_D, 32'd6});
    exp_q.push_back({A_D, 32'd6});
    send_cmd(11'd638, 10'd479, 11'd5, 10'd4, 3'd6, 1'b0, acc);
    wait_done(bd, 200);
    checks++;
    if (obs_q.size() - bo != 4) begin
      errors++;
      $display("FAIL clip_count: got %0d beats, required 4", obs_q.size() - bo);
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (bo + i >= obs_q.size() || obs_q[bo + i] !== exp_q[i]) begin
        errors++;
        $display("FAIL clip_beat%0d: got %h, required %h", i,
                 (bo + i < obs_q.size()) ? obs_q[bo + i] : 64'hx, exp_q[i]);
      end
    end
  endtask

  task automatic test_empty();
    int bo, bd, bb, br, acc;
    logic [10:0] xs[2];
    logic [10:0] ws[2];
    xs[0] = 11'd5;   ws[0] = 11'd0;
    xs[1] = 11'd640; ws[1] = 11'd4;
    for (int k = 0; k < 2; k++) begin
      bo = obs_q.size(); bd = done_cnt; bb = busy_cnt; br = rd_cyc.size();
      send_cmd(xs[k], 10'd5, ws[k], 10'd3, 3'd1, 1'b0, acc);
      wait_done(bd, 20);
      checks++;
      if (done_cyc != acc + 1 || done_cnt - bd != 1) begin
        errors++;
        $display("FAIL empty%0d_done: done cyc %0d count %0d, required %0d and 1",
                 k, done_cyc, done_cnt - bd, acc + 1);
      end
      checks++;
      if (obs_q.size() != bo || rd_cyc.size() != br || busy_cnt != bb) begin
        errors++;
        $display("FAIL empty%0d_quiet: wr %0d rd %0d busy %0d, required 0 0 0", k,
                 obs_q.size() - bo, rd_cyc.size() - br, busy_cnt - bb);
      end
    end
  endtask

  task automatic test_vblank();
    int bo, bd, br, acc;
    logic [31:0] tbl[3];
    tbl[0] = 32'd100; tbl[1] = 32'd57; tbl[2] = 32'd0;
    bo = obs_q.size(); bd = done_cnt; br = rd_cyc.size();
    exp_q.delete();
    exp_q.push_back({A_X, 32'd1});
    exp_q.push_back({A_Y, 32'd2});
    exp_q.push_back({A_D, 32'd3});
    send_cmd(11'd1, 10'd2, 11'd1, 10'd1, 3'd3, 1'b1, acc);
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < 20 && !rd_valid; j++) begin
        @(posedge clock); #1;
      end
      rd_ready = 1'b1;
      rd_data = tbl[k];
      @(posedge clock); #1;
      rd_ready = 1'b0;
      rd_data = '0;
    end
    wait_done(bd, 100);
    checks++;
    if (rd_cyc.size() - br != 3 || rd_addr_seen !== A_S) begin
      errors++;
      $display("FAIL vbl_reads: got %0d reads at %h, required 3 at %h",
               rd_cyc.size() - br, rd_addr_seen, A_S);
    end
    if (rd_cyc.size() - br == 3) begin
      checks++;
      if (rd_cyc[br + 1] - rd_cyc[br] != 2 || rd_cyc[br + 2] - rd_cyc[br + 1] != 2) begin
        errors++;
        $display("FAIL vbl_gap: read spacing %0d %0d, required 2 2",
                 rd_cyc[br + 1] - rd_cyc[br], rd_cyc[br + 2] - rd_cyc[br + 1]);
      end
      checks++;
      if (obs_q.size() == bo || obs_cyc[bo] != rd_cyc[br + 2] + 1) begin
        errors++;
        $display("FAIL vbl_first_write: first write cyc %0d, required %0d",
                 (obs_q.size() > bo) ? obs_cyc[bo] : -1, rd_cyc[br + 2] + 1);
      end
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (bo + i >= obs_q.size() || obs_q[bo + i] !== exp_q[i]) begin
        errors++;
        $display("FAIL vbl_beat%0d: got %h, required %h", i,
                 (bo + i < obs_q.size()) ? obs_q[bo + i] : 64'hx, exp_q[i]);
      end
    end
  endtask

  task automatic test_abort();
    int bo, bd, ba, acc;
    bo = obs_q.size(); bd = done_cnt; ba = aborted_cnt;
    wr_ready = 1'b0;
    send_cmd(11'd0, 11'd0 == 11'd0 ? 10'd0 : 10'd0, 11'd4, 10'd1, 3'd2, 1'b0, acc);
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < 20 && !wr_valid; j++) begin
        @(posedge clock); #1;
      end
      wr_ready = 1'b1;
      @(posedge clock); #1;
      wr_ready = 1'b0;
    end
    abort = 1'b1;
    for (int s = 0; s < 5; s++) begin
      @(posedge clock); #1;
      checks++;
      if (wr_valid !== 1'b1 || wr_addr !== A_D || wr_data !== 32'd2 || done !== 1'b0) begin
        errors++;
        $display("FAIL abort_stall%0d: valid=%b addr=%h data=%h done=%b, required 1 %h 2 0",
                 s, wr_valid, wr_addr, wr_data, done, A_D);
      end
    end
    wr_ready = 1'b1;
    @(posedge clock); #1;
    wr_ready = 1'b0;
    checks++;
    if (done !== 1'b1 || aborted !== 1'b1 || wr_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_end: done=%b aborted=%b wr_valid=%b, required 1 1 0",
               done, aborted, wr_valid);
    end
    @(posedge clock); #1;
    abort = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    checks++;
    if (obs_q.size() - bo != 4 || done_cnt - bd != 1 || aborted_cnt - ba != 1) begin
      errors++;
      $display("FAIL abort_totals: beats %0d done %0d aborted %0d, required 4 1 1",
               obs_q.size() - bo, done_cnt - bd, aborted_cnt - ba);
    end
    wr_ready = 1'b1;
  endtask

  task automatic test_reset_mid();
    int bo, bd, acc;
    wr_ready = 1'b0;
    send_cmd(11'd3, 10'd4, 11'd2, 10'd1, 3'd7, 1'b0, acc);
    checks++;
    if (wr_valid !== 1'b1) begin
      errors++;
      $display("FAIL midrst_pre: wr_valid=%b, required 1", wr_valid);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (wr_valid !== 1'b0 || busy !== 1'b0 || wr_addr !== 32'd0 || wr_data !== 32'd0) begin
      errors++;
      $display("FAIL midrst_clear: valid=%b busy=%b addr=%h data=%h, required 0 0 0 0",
               wr_valid, busy, wr_addr, wr_data);
    end
    wr_ready = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;
    bo = obs_q.size(); bd = done_cnt;
    exp_q.delete();
    exp_q.push_back({A_X, 32'd3});
    exp_q.push_back({A_Y, 32'd4});
    exp_q.push_back({A_D, 32'd7});
    exp_q.push_back({A_D, 32'd7});
    send_cmd(11'd3, 10'd4, 11'd2, 10'd1, 3'd7, 1'b0, acc);
    wait_done(bd, 100);
    checks++;
    if (obs_q.size() - bo != 4) begin
      errors++;
      $display("FAIL midrst_count: got %0d beats, required 4", obs_q.size() - bo);
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (bo + i >= obs_q.size() || obs_q[bo + i] !== exp_q[i]) begin
        errors++;
        $display("FAIL midrst_beat%0d: got %h, required %h", i,
                 (bo + i < obs_q.size()) ? obs_q[bo + i] : 64'hx, exp_q[i]);
      end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    cmd_valid = 1'b0; cmd_x = '0; cmd_y = '0; cmd_w = '0; cmd_h = '0;
    cmd_color = '0; cmd_vblank = 1'b0; abort = 1'b0;
    wr_ready = 1'b1; rd_ready = 1'b0; rd_data = '0;
    test_reset();
    test_fill();
    test_clip();
    test_empty();
    test_vblank();
    test_abort();
    test_reset_mid();
    do_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_rect_fill_sequencer.md
Name: vga_rect_fill_sequencer

Overview:
Bus-master sequencer that fills screen rectangles with a solid colour by issuing register writes to the VGA peripheral's worker port (X_ADDR, Y_ADDR, DATA) on the Simple_Worker_Mem_IF bus. It optionally polls SCANLINE to start a fill only during vertical blanking. It offloads pixel loops from the CPU and sits between a command source (CPU-side register block or DMA) and the VGA peripheral.

Parameters:
VGA_ADDR, 'h1000_0000, base address of the VGA peripheral (32-byte aligned)
DEPTH, 3, VRAM bits per pixel; 0 means direct 24-bit colour
W_DIV_1280, 1, MAX_W = 1280 >> W_DIV_1280 (default 640)
H_DIV_960, 1, MAX_H = 960 >> H_DIV_960 (default 480)

Ports:
clock  in  1  system/bus clock
reset_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted on an edge where cmd_valid && cmd_ready
cmd_x / cmd_y  in  11 / 10  top-left pixel, unsigned
cmd_w / cmd_h  in  11 / 10  width / height in pixels
cmd_color  in  CW  colour index; CW = DEPTH, or 24 when DEPTH==0
cmd_vblank  in  1  wait for SCANLINE==0 before the first write
abort  in  1  level; ends the current command at the next beat boundary
busy  out  1  command in progress
done  out  1  one-cycle pulse at command completion (normal, empty or aborted)
aborted  out  1  one-cycle pulse coincident with done when ended by abort
wr_addr  out  32  master write address
wr_data  out  32  master write data
wr_byteEn  out  4  always 4'hF while wr_valid
wr_valid  out  1  write beat request
wr_ready  in  1  worker write acknowledge
rd_addr  out  32  master read address (SCANLINE only)
rd_byteEn  out  4  always 4'hF while rd_valid
rd_valid  out  1  read request
rd_ready  in  1  worker read acknowledge, rd_data valid in the same cycle
rd_data  in  32  read data

Behaviour:
- Reset values: cmd_ready=0, busy=0, done=0, aborted=0, wr_valid=0, rd_valid=0, and wr_addr, wr_data, wr_byteEn, rd_addr, rd_byteEn all 0. cmd_ready rises on the first edge after reset_n deasserts.
- Handshake: a beat completes on an edge where valid && ready. On that edge the master either presents the next beat or drops valid. It never changes addr or data and never drops valid while a beat is pending. A worker stall of any length is legal.
- Addresses: X = VGA_ADDR+'h04, Y = VGA_ADDR+'h08, DATA = VGA_ADDR+'h0C, SCANLINE = VGA_ADDR+'h1C. Data is zero-extended to 32 bits.
- Clipping on accept: x_end = min(cmd_x+cmd_w, MAX_W) and y_end = min(cmd_y+cmd_h, MAX_H), computed 12/11-bit to avoid wrap.
- Empty commands: if cmd_w==0, cmd_h==0, cmd_x>=MAX_W or cmd_y>=MAX_H, the command is empty and issues no beats. busy stays 0 and done pulses on the next edge.
- FSM:
  - IDLE: cmd_ready=1. On accept, latch clipped bounds and colour. Go to VBL if cmd_vblank, else WR_X.
  - VBL: rd_valid=1 at SCANLINE. On a rd_ready edge, go to WR_X if rd_data[9:0]==0, else re-issue with one idle cycle between reads.
  - WR_X: write cur_x=cmd_x. Then WR_Y.
  - WR_Y: write cur_y. Then WR_DATA.
  - WR_DATA: write colour and increment the pixel counter. After the beat at pixel x_end-1, increment cur_y. If cur_y+1==y_end go to DONE, else WR_X. The peripheral auto-increments X, so no per-pixel X writes are issued.
  - DONE: done=1 for one cycle, then IDLE.
- busy=1 in all states except IDLE.
- Abort:
  - Sampled at each beat completion or during an idle VBL cycle; go to DONE with aborted=1.
  - A pending beat always finishes first.
  - abort asserted in IDLE has no effect.
- reset_n low mid-beat: all outputs clear immediately (asynchronous). A partial command is lost.
- Throughput: zero bubble cycles between write beats when the worker is ready.

Decomposition:
- Package vga_pkg holds:
  - register offsets (EN, X_ADDR, Y_ADDR, DATA, PALETTE_ADDR, COLOR, SCANLINE);
  - MAX_W/MAX_H helper functions of W_DIV_1280/H_DIV_960;
  - the FSM enum typedef;
  - a fill_cmd_t struct {x, y, w, h, color, vblank}.
- One sub-module, vga_fill_clip: combinational clipping and empty detection, unit-testable on its own.

Test Plan:
1. Default params, worker always ready. cmd x=10, y=20, w=3, h=2, color=5, no vblank -> beats (X,10), (Y,20), (D,5)x3, (X,10), (Y,21), (D,5)x3. That is 10 beats, with done pulsing once one cycle after the last.
2. Clipping: x=638, y=479, w=5, h=4 -> beats (X,638), (Y,479), (D,c)x2 only, then done.
3. Empty commands: w=0, then x=640 -> no wr_valid or rd_valid ever, and done pulses one cycle after each accept.
4. cmd_vblank=1 with the worker returning SCANLINE 100, 57, then 0 -> exactly 3 reads, then the first write (X) follows the third rd_ready.
5. Abort: assert abort during the 2nd DATA beat while wr_ready is held low for 5 cycles. wr_valid and data stay stable until ready; no further beats; done and aborted pulse together.
6. Assert reset_n low mid-beat -> wr_valid=0 within the same cycle. After release, a new cmd runs from scratch with correct beats.
